// File: rtl/vga_sync_gen_pkg.sv
// Shared VGA timing constants, counter widths and the sync bundle type.
// Defaults describe 640x480@60 driven from a 50 MHz system clock.
package vga_sync_gen_pkg;

  localparam int H_SIZE = 10;
  localparam int V_SIZE = 10;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_CLK_DIV   = 2;
  localparam int DEF_OUT_DLY   = 1;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } sync_bus_t;

  localparam int SYNC_BUS_W = $bits(sync_bus_t);

  // A counter for N states still needs one bit when N is 1.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Parameterized shift register that keeps sync strobes aligned with
// registered pixel data; DEPTH of zero degenerates to a plain wire.
module vga_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, rst_val};
    assign dout = din;
  end else begin : g_regs
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    // Every stage shifts on every clock, regardless of the timing enable.
    always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rst) begin
          stage_q[i] <= rst_val;
        end else begin
          stage_q[i] <= stage_d[i];
        end
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing core: pixel-rate tick, hc/vc counters, sync/blank decodes and
// delayed copies of the strobes that line up with registered downstream RGB.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter bit SYNC_POL  = 1'b0,
  parameter int OUT_DLY   = DEF_OUT_DLY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              pix_tick,
  output logic [H_SIZE-1:0] hc,
  output logic [V_SIZE-1:0] vc,
  output logic              video_on,
  output logic              frame_start,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              video_on_o
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = clog2_min1(CLK_DIV);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [H_SIZE-1:0] H_LAST   = H_SIZE'(H_TOTAL - 1);
  localparam logic [V_SIZE-1:0] V_LAST   = V_SIZE'(V_TOTAL - 1);
  localparam logic [H_SIZE-1:0] H_VIS    = H_SIZE'(H_DISPLAY);
  localparam logic [V_SIZE-1:0] V_VIS    = V_SIZE'(V_DISPLAY);
  localparam logic [H_SIZE-1:0] HS_FIRST = H_SIZE'(H_DISPLAY + H_FRONT);
  localparam logic [H_SIZE-1:0] HS_LAST  = H_SIZE'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [V_SIZE-1:0] VS_FIRST = V_SIZE'(V_DISPLAY + V_FRONT);
  localparam logic [V_SIZE-1:0] VS_LAST  = V_SIZE'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  if (H_TOTAL - 1 >= (1 << H_SIZE)) begin : g_h_range_err
    $error("vga_sync_gen: H_TOTAL-1 does not fit in H_SIZE bits");
  end
  if (V_TOTAL - 1 >= (1 << V_SIZE)) begin : g_v_range_err
    $error("vga_sync_gen: V_TOTAL-1 does not fit in V_SIZE bits");
  end
  if (CLK_DIV < 1 || OUT_DLY < 0) begin : g_param_err
    $error("vga_sync_gen: CLK_DIV must be >= 1 and OUT_DLY >= 0");
  end

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic              pix_tick_q, pix_tick_d;
  logic [H_SIZE-1:0] hc_q, hc_d;
  logic [V_SIZE-1:0] vc_q, vc_d;
  sync_bus_t         sync_now, sync_idle, sync_dly;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q  <= '0;
      pix_tick_q <= 1'b0;
      hc_q       <= '0;
      vc_q       <= '0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      pix_tick_q <= pix_tick_d;
      hc_q       <= hc_d;
      vc_q       <= vc_d;
    end
  end

  // While en is low every register holds, including a pending tick, so the
  // raster resumes exactly where it stopped; the visible tick is masked.
  always_comb begin
    div_cnt_d  = div_cnt_q;
    pix_tick_d = pix_tick_q;
    hc_d       = hc_q;
    vc_d       = vc_q;
    if (en) begin
      div_cnt_d  = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
      pix_tick_d = (div_cnt_q == DIV_LAST);
      if (pix_tick_q) begin
        if (hc_q == H_LAST) begin
          hc_d = '0;
          vc_d = (vc_q == V_LAST) ? '0 : vc_q + V_SIZE'(1);
        end else begin
          hc_d = hc_q + H_SIZE'(1);
        end
      end
    end
  end

  always_comb begin
    sync_now.video_on = (hc_q < H_VIS) && (vc_q < V_VIS);
    sync_now.hsync    = ((hc_q >= HS_FIRST) && (hc_q <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    sync_now.vsync    = ((vc_q >= VS_FIRST) && (vc_q <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    sync_idle.hsync    = ~SYNC_POL;
    sync_idle.vsync    = ~SYNC_POL;
    sync_idle.video_on = 1'b0;
  end

  vga_delay_line #(
    .WIDTH(SYNC_BUS_W),
    .DEPTH(OUT_DLY)
  ) u_delay (
    .clk    (clk),
    .rst    (rst),
    .rst_val(sync_idle),
    .din    (sync_now),
    .dout   (sync_dly)
  );

  assign pix_tick    = pix_tick_q && en;
  assign hc          = hc_q;
  assign vc          = vc_q;
  assign video_on    = sync_now.video_on;
  assign frame_start = pix_tick && (hc_q == '0) && (vc_q == '0);
  assign hsync_o     = sync_dly.hsync;
  assign vsync_o     = sync_dly.vsync;
  assign video_on_o  = sync_dly.video_on;

endmodule
